// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, limits and helpers for the 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam int MAX_DIGITS = 8;

    // Digit enable pattern for one digit; active_low inverts it for common-anode drivers.
    function automatic logic [MAX_DIGITS-1:0] idx_to_onehot(input logic [2:0] idx,
                                                            input logic       active_low);
        logic [MAX_DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: loadable down-counter that parks at zero and flags terminal count.
module seg_scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    // Reload has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed N-digit 7-segment scan controller driving one shared decoder.
// Optional leading-zero blanking is built when SEG_SCAN_LZ_BLANK_EN is defined.
import seg_scan_pkg::*;

module seg_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 16,
    parameter int DIGIT_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [TW-1:0] SHOW_LOAD   = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] BLANK_LOAD  = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam state_e        ENTRY_STATE = (BLANK_CYCLES > 0) ? BLANK : SHOW;
    localparam logic [TW-1:0] ENTRY_LOAD  = (BLANK_CYCLES > 0) ? BLANK_LOAD : SHOW_LOAD;
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_DIGITS - 1);
    localparam logic          ACT_LOW     = (DIGIT_ACTIVE_LOW != 0);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fdone_q, fdone_d;

    logic                    tmr_load;
    logic [TW-1:0]           tmr_val;
    logic [TW-1:0]           tmr_cnt;
    logic                    tmr_tc;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   suppress;

    seg_scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_o    (tmr_cnt),
        .tc_o       (tmr_tc)
    );

    // Scan sequencing: pick the next state/digit and reload the timer on every state entry.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = SHOW_LOAD;
        boundary = 1'b0;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = ENTRY_STATE;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = ENTRY_LOAD;
                end
                BLANK: begin
                    if (tmr_tc) begin
                        state_d  = SHOW;
                        tmr_load = 1'b1;
                        tmr_val  = SHOW_LOAD;
                    end
                end
                SHOW: begin
                    if (tmr_tc) begin
                        state_d  = ENTRY_STATE;
                        tmr_load = 1'b1;
                        tmr_val  = ENTRY_LOAD;
                        if (idx_q == LAST_IDX) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Shadow only changes while idle or at a frame boundary so a frame never mixes old and new data.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if ((state_q == IDLE) || boundary) begin
            if (load) begin
                shadow_d     = digits_in;
                shadow_dp_d  = dp_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                shadow_d     = pend_q;
                shadow_dp_d  = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_d       = digits_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A zero digit with only zeros above it stays dark unless its decimal point is set; digit 0 always lights.
    always_comb begin
        logic zero_run;
        suppress = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (shadow_d[4*k +: 4] == 4'd0);
            suppress[k] = zero_run && !shadow_dp_d[k];
        end
    end
`else
    assign suppress = '0;
`endif

    // Output values for the coming cycle, so every output lines up with the registered state.
    always_comb begin
        int  sel_idx;
        logic next_tc;
        sel_idx = int'(idx_d);
        bcd_d   = 4'd0;
        dp_d    = 1'b0;
        sel_d   = {NUM_DIGITS{ACT_LOW}};
        if (state_d != IDLE) begin
            bcd_d = shadow_d[4*sel_idx +: 4];
            dp_d  = shadow_dp_d[idx_d] && !suppress[idx_d];
        end
        if ((state_d == SHOW) && !suppress[idx_d]) begin
            sel_d = NUM_DIGITS'(idx_to_onehot(3'(idx_d), ACT_LOW));
        end
        next_tc = tmr_load ? (tmr_val == '0) : (tmr_cnt <= TW'(1));
        fdone_d = (state_d == SHOW) && (idx_d == LAST_IDX) && next_tc;
    end

    // State, data and output registers with synchronous reset that aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            bcd_q        <= 4'd0;
            dp_q         <= 1'b0;
            sel_q        <= {NUM_DIGITS{ACT_LOW}};
            fdone_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            fdone_q      <= fdone_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign dp_out     = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (4 digits, 4 lit cycles, 2 blank cycles).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    seg_scan_ctrl #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .BLANK_CYCLES     (2),
        .DIGIT_ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [15:0] d, input logic [3:0] p);
        rst_n     = r;
        en        = e;
        load      = l;
        digits_in = d;
        dp_in     = p;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expSel, input logic [3:0] expBcd,
                               input logic expDp, input logic expFd);
        checks++;
        assert (digit_sel === expSel) else begin
            failures++;
            $error("[TB] FAIL %s digit_sel observed=%b expected=%b", tag, digit_sel, expSel);
        end
        checks++;
        assert (bcd_out === expBcd) else begin
            failures++;
            $error("[TB] FAIL %s bcd_out observed=%0d expected=%0d", tag, bcd_out, expBcd);
        end
        checks++;
        assert (dp_out === expDp) else begin
            failures++;
            $error("[TB] FAIL %s dp_out observed=%b expected=%b", tag, dp_out, expDp);
        end
        checks++;
        assert (frame_done === expFd) else begin
            failures++;
            $error("[TB] FAIL %s frame_done observed=%b expected=%b", tag, frame_done, expFd);
        end
    endtask

    task automatic checkSelFd(input string tag, input logic [3:0] expSel, input logic expFd);
        checks++;
        assert (digit_sel === expSel) else begin
            failures++;
            $error("[TB] FAIL %s digit_sel observed=%b expected=%b", tag, digit_sel, expSel);
        end
        checks++;
        assert (frame_done === expFd) else begin
            failures++;
            $error("[TB] FAIL %s frame_done observed=%b expected=%b", tag, frame_done, expFd);
        end
    endtask

    // One digit slot starting at its first blank cycle: 2 dark cycles then 4 lit (or dark if suppressed).
    task automatic checkSlot(input string tag, input int idx, input logic [3:0] bcd, input logic dp,
                             input logic lit, input logic doLoad, input logic [15:0] ld,
                             input logic [3:0] ldDp);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        for (int b = 0; b < 2; b++) begin
            checkOutput($sformatf("%s_d%0d_blank%0d", tag, idx, b), 4'b0000, bcd, dp, 1'b0);
            tick();
        end
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("%s_d%0d_show%0d", tag, idx, s), lit ? oh : 4'b0000, bcd, dp,
                        (idx == 3) && (s == 3));
            if ((s == 3) && doLoad) begin
                load      = 1'b1;
                digits_in = ld;
                dp_in     = ldDp;
            end
            tick();
            load = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset held with en and load active.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        repeat (3) tick();
        checkOutput("reset", 4'b0000, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hFFFF, 4'hF);
        tick();
        checkOutput("post_reset_shadow", 4'b0000, 4'd0, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        checkSelFd("idle", 4'b0000, 1'b0);

        // Scan order with data loaded while idle.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h4321, 4'b0100);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h4321, 4'b0100);
        tick();
        checkSlot("scan", 0, 4'd1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("scan", 1, 4'd2, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("scan", 2, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("scan", 3, 4'd4, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Coherency: load mid-frame stays pending until the wrap.
        checkSlot("coh", 0, 4'd1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkOutput("coh_d1_blank0", 4'b0000, 4'd2, 1'b0, 1'b0);
        tick();
        checkOutput("coh_d1_blank1", 4'b0000, 4'd2, 1'b0, 1'b0);
        tick();
        checkOutput("coh_d1_show0", 4'b0010, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h9876, 4'b0000);
        tick();
        load = 1'b0;
        for (int s = 1; s < 4; s++) begin
            checkOutput($sformatf("coh_d1_show%0d", s), 4'b0010, 4'd2, 1'b0, 1'b0);
            tick();
        end
        checkSlot("coh", 2, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("coh", 3, 4'd4, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("new", 0, 4'd6, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("new", 1, 4'd7, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("new", 2, 4'd8, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("new", 3, 4'd9, 1'b0, 1'b1, 1'b1, 16'h1234, 4'b0001);

        // Load on the frame_done cycle lands in the very next frame; then abort during digit 2.
        checkSlot("bnd", 0, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("bnd", 1, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkOutput("abort_d2_blank0", 4'b0000, 4'd2, 1'b0, 1'b0);
        tick();
        checkOutput("abort_d2_blank1", 4'b0000, 4'd2, 1'b0, 1'b0);
        tick();
        checkOutput("abort_d2_show0", 4'b0100, 4'd2, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        checkSelFd("abort_off", 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkSelFd($sformatf("abort_idle%0d", i), 4'b0000, 1'b0);
        end
        en = 1'b1;
        tick();
        checkSlot("restart", 0, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

        // Mid-scan reset during digit 3.
        checkSlot("rst", 1, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("rst", 2, 4'd2, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkOutput("rst_d3_blank0", 4'b0000, 4'd1, 1'b0, 1'b0);
        tick();
        checkOutput("rst_d3_blank1", 4'b0000, 4'd1, 1'b0, 1'b0);
        tick();
        checkOutput("rst_d3_show0", 4'b1000, 4'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        checkOutput("midreset", 4'b0000, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        checkSlot("after_rst", 0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Leading zeros: suppressed slots keep their time when blanking is built in.
        en = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0050, 4'b0000);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0050, 4'b0000);
        tick();
        checkSlot("lz50", 0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("lz50", 1, 4'd5, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("lz50", 2, 4'd0, 1'b0, !LZ, 1'b0, 16'h0, 4'h0);
        checkSlot("lz50", 3, 4'd0, 1'b0, !LZ, 1'b1, 16'h0000, 4'b0000);
        checkSlot("lz00", 0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkSlot("lz00", 1, 4'd0, 1'b0, !LZ, 1'b0, 16'h0, 4'h0);
        checkSlot("lz00", 2, 4'd0, 1'b0, !LZ, 1'b0, 16'h0, 4'h0);
        checkSlot("lz00", 3, 4'd0, 1'b0, !LZ, 1'b0, 16'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit 7-segment display that shares one bcd_to_7seg decoder across all digits. Holds a frame-coherent shadow copy of the BCD digits and steps through them one at a time. For each digit it drives the shared decoder's BCD input and the decimal point, then asserts a one-hot digit enable. A dead-time gap between digits suppresses ghosting. Sits between the numeric datapath (counters, clocks) and the top-level that instantiates the decoder and pads.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8).
REFRESH_DIV, 50000, clk cycles each digit is lit (>=1).
BLANK_CYCLES, 16, dead-time cycles before each digit with all enables off (0 = no blanking phase).
DIGIT_ACTIVE_LOW, 0, 1 = digit_sel asserted low (PNP/common-anode drivers).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous reset, active low.
en  in  1  scan enable; low = display dark.
load  in  1  single-cycle strobe; capture digits_in/dp_in.
digits_in  in  4*NUM_DIGITS  BCD digits; digit i = bits [4i+3:4i], digit 0 = least significant (rightmost).
dp_in  in  NUM_DIGITS  decimal point per digit, active high.
bcd_out  out  4  BCD value to the shared decoder.
dp_out  out  1  decimal point for the current digit.
digit_sel  out  NUM_DIGITS  one-hot digit enable (polarity per DIGIT_ACTIVE_LOW).
frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a clk edge) gives: state IDLE, idx 0, shadow and pending registers 0, bcd_out 0, dp_out 0, frame_done 0, digit_sel all inactive. Reset mid-scan aborts the scan on the same edge.
- FSM states are IDLE, BLANK and SHOW. Counter widths are $clog2 of the parameter values. The timer reloads on every state entry.
- IDLE: digit_sel is inactive. When en=1, the next state is BLANK with idx=0.
- BLANK: lasts BLANK_CYCLES cycles. digit_sel is inactive. bcd_out and dp_out already show shadow[idx] so the decoder settles before the digit lights. If BLANK_CYCLES=0, the FSM goes straight to SHOW.
- SHOW: lasts REFRESH_DIV cycles. digit_sel has only bit idx asserted. bcd_out and dp_out are held.
- End of a SHOW slot:
  - If idx < NUM_DIGITS-1: idx increments and the FSM enters BLANK.
  - Otherwise idx wraps to 0, frame_done pulses during that last SHOW cycle, and the FSM enters BLANK.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- en=0 in any state: the next cycle is IDLE with digit_sel inactive and idx reset to 0. Re-enabling always restarts at digit 0 with a BLANK phase. frame_done does not pulse for an aborted frame.
- Load coherency:
  - In IDLE, load writes the shadow directly on the next edge.
  - While scanning, load writes the pending register and sets a pending flag. The shadow takes pending at the frame boundary (wrap to idx 0), so a frame never mixes old and new data.
  - If load coincides with the boundary, the new data goes straight into the shadow for the next frame.
  - A later load before the boundary overwrites pending; the last one wins.
- BCD values 10..15 pass through unchanged; the decoder shows a dash.

Optional Feature:
- Macro SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
- With the macro defined:
  - A digit is suppressed if it is 0, it is not digit 0, and every more-significant digit is also 0.
  - A suppressed digit keeps its time slot, but digit_sel stays inactive and dp_out=0 for that slot. Exception: if its dp bit is set, the digit is shown.
  - Suppression is evaluated from the shadow.
- Without the macro, every digit is always lit.

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum (IDLE, BLANK, SHOW);
  - the localparam MAX_DIGITS=8;
  - a function idx_to_onehot(idx, active_low).
- Sub-module seg_scan_timer: a loadable down-counter with a terminal-count pulse, parameterised by width. It is instantiated once and reloaded with BLANK_CYCLES or REFRESH_DIV on each state entry.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
1. Reset: rst_n=0 for 3 cycles with en=1 and load=1 -> digit_sel=0000, bcd_out=0, dp_out=0, frame_done=0. After release, shadow reads 0.
2. Scan order: load digits_in=16'h4321 and dp_in=4'b0100, then en=1 -> per digit, 2 blank cycles with digit_sel=0000 followed by 4 cycles lit:
   - digit_sel 0001 / bcd 1;
   - digit_sel 0010 / bcd 2;
   - digit_sel 0100 / bcd 3 / dp 1;
   - digit_sel 1000 / bcd 4.
   frame_done pulses exactly once every 24 cycles.
3. Coherency: load 16'h9876 while digit 1 is lit -> digits 2 and 3 still show 3 and 4. The next frame shows 6,7,8,9. A load on the frame_done cycle takes effect in the very next frame.
4. Enable abort: drop en during digit 2 SHOW -> next cycle digit_sel=0000 and no frame_done. Re-raise en -> 2 blank cycles, then digit 0.
5. Mid-scan reset: rst_n=0 for 1 cycle during digit 3 -> all outputs return to reset values. With en=1, the scan restarts at digit 0 showing 0.
6. SEG_SCAN_LZ_BLANK_EN with digits 16'h0050 -> digits 3 and 2 keep digit_sel=0000 while the frame stays 24 cycles. Digits 16'h0000 -> only digit 0 lights, showing 0.
